// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/ack, in-order instruction
// stream towards the decoder, and the redirect strobe from branch/jump logic.
//   master : the fetch unit (drives ot_*, samples in_*)
//   slave  : memory / consumer / branch logic side
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  ot_mem_req;
    logic [ADDR_WIDTH-1:0] ot_mem_addr;
    logic                  in_mem_ack;
    logic [15:0]           in_mem_data;
    logic                  ot_valid;
    logic                  in_ready;
    logic [15:0]           ot_instruction;
    logic [ADDR_WIDTH-1:0] ot_pc;
    logic                  in_redirect;
    logic [ADDR_WIDTH-1:0] in_redirect_target;

    modport master (
        output ot_mem_req, ot_mem_addr, ot_valid, ot_instruction, ot_pc,
        input  in_mem_ack, in_mem_data, in_ready, in_redirect, in_redirect_target
    );

    modport slave (
        input  ot_mem_req, ot_mem_addr, ot_valid, ot_instruction, ot_pc,
        output in_mem_ack, in_mem_data, in_ready, in_redirect, in_redirect_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding word request
// at a time, buffers up to two returned instructions with their PCs and presents
// them in order. A redirect flushes the buffer; a response already in flight is
// drained and discarded before fetching resumes at the target.
// Ports:
//   in_clk, in_rst : clock (rising edge), asynchronous active-high reset
//   bus (master)   : memory request/ack, valid/ready instruction stream, redirect
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                        in_clk,
    input logic                        in_rst,
    instruction_fetch_unit_if.master   bus
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic [1:0]            count_q, count_d;
    logic                  head_q, head_d;
    logic [15:0]           fifo_ins_q [2];
    logic [ADDR_WIDTH-1:0] fifo_pc_q  [2];

    logic mem_req;
    logic push;
    logic pop;
    logic tail;
    logic not_empty;

    assign not_empty = (count_q != 2'd0);
    assign mem_req   = !in_rst && ((state_q == DRAIN) || (count_q != 2'd2));
    assign push      = mem_req && bus.in_mem_ack && (state_q == FETCH) && !bus.in_redirect;
    assign pop       = not_empty && bus.in_ready && !bus.in_redirect;
    // Push only happens with count < 2, so the tail is head offset by count[0].
    assign tail      = head_q ^ count_q[0];

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        count_d      = count_q;
        head_d       = head_q;
        if (bus.in_redirect) begin
            count_d = 2'd0;
            if (mem_req && !bus.in_mem_ack) begin
                // Response still owed at the old address: keep it stable, drain it.
                state_d      = DRAIN;
                pending_pc_d = bus.in_redirect_target;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = bus.in_redirect_target;
            end
        end else if (state_q == DRAIN) begin
            if (bus.in_mem_ack) begin
                state_d    = FETCH;
                fetch_pc_d = pending_pc_q;
            end
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + PC_ONE;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= RESET_PC;
            count_q      <= 2'd0;
            head_q       <= 1'b0;
            fifo_ins_q   <= '{default: '0};
            fifo_pc_q    <= '{default: '0};
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            count_q      <= count_d;
            head_q       <= head_d;
            if (push) begin
                fifo_ins_q[tail] <= bus.in_mem_data;
                fifo_pc_q[tail]  <= fetch_pc_q;
            end
        end
    end

    assign bus.ot_mem_req     = mem_req;
    assign bus.ot_mem_addr    = fetch_pc_q;
    assign bus.ot_valid       = not_empty;
    assign bus.ot_instruction = not_empty ? fifo_ins_q[head_q] : 16'h0000;
    assign bus.ot_pc          = not_empty ? fifo_pc_q[head_q] : '0;

endmodule
